// File: rtl/frame_writer.sv
// Address assignment, FIFO buffering and DDR write-port issue for camera pixel words.
// frame_written pulses once all words of a frame have been handed to memory.

package frame_writer_pkg;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 128;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;
endpackage

module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH   = 16,
  parameter int unsigned       FRAME_WORDS  = 38400,
  parameter int unsigned       ADDR_STEP    = 4,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = 25'h25800,
  parameter int unsigned       NUM_SLOTS    = 6
) (
  input  logic              p_clk,
  input  logic              rst,
  input  logic              take_pic,
  input  logic [DATA_W-1:0] p_data,
  input  logic              data_valid,
  input  logic              frame_done,
  input  logic [2:0]        last_frame,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_written,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       slot, slot_nxt;
  logic [IDX_W-1:0] word_idx, word_idx_nxt;

  wr_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic             drain_active, drain_active_nxt;
  logic             written_nxt, overflow_nxt;

  logic              valid_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  logic              flush_c;
  logic              pop_c, push_c, drop_c, full_c, load_c;
  logic [2:0]        slot_in_c, slot_sel_c;
  logic [IDX_W-1:0]  idx_sel_c;
  logic [ADDR_W-1:0] addr_c;
  logic [CNT_W-1:0]  avail_c, fill_c;
  logic [PTR_W-1:0]  rd_ptr_c;
  wr_entry_t         entry_c;

  assign flush_c = rst | take_pic;

  // Slot indices past the last slot fold onto it so addresses never leave the frame area.
  assign slot_in_c = (last_frame >= 3'(NUM_SLOTS)) ? 3'(NUM_SLOTS - 1) : last_frame;

  assign pop_c    = wr_valid & wr_ready;
  assign full_c   = (count == CNT_W'(FIFO_DEPTH));
  assign avail_c  = count - CNT_W'(pop_c);
  assign fill_c   = count - CNT_W'(pop_c) + CNT_W'(push_c);
  assign rd_ptr_c = pop_c ? rptr + PTR_W'(1) : rptr;
  assign load_c   = ~wr_valid | pop_c;
  assign addr_c   = ADDR_W'(slot_sel_c) * FRAME_STRIDE
                  + ADDR_W'(idx_sel_c) * ADDR_W'(ADDR_STEP);
  assign entry_c  = '{addr: addr_c, data: p_data};

  always_ff @(posedge p_clk) begin
    if (flush_c) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, address generation, drain tracking and output-stage selection.
  always_comb begin
    state_nxt        = state;
    slot_nxt         = slot;
    word_idx_nxt     = word_idx;
    slot_sel_c       = slot;
    idx_sel_c        = word_idx;
    push_c           = 1'b0;
    drop_c           = 1'b0;
    drain_cnt_nxt    = drain_cnt;
    drain_active_nxt = drain_active;
    written_nxt      = 1'b0;
    valid_nxt        = wr_valid;
    addr_nxt         = wr_addr;
    data_nxt         = wr_data;

    case (state)
      IDLE: begin
        if (data_valid) begin
          slot_sel_c = slot_in_c;
          idx_sel_c  = '0;
          slot_nxt   = slot_in_c;
          state_nxt  = FRAME;
        end
      end
      FRAME: ;
      default: state_nxt = IDLE;
    endcase

    // A word dropped on a full FIFO still consumes its index to keep later pixels aligned.
    if (data_valid) begin
      if (32'(idx_sel_c) >= FRAME_WORDS) begin
        drop_c = 1'b1;
      end else begin
        word_idx_nxt = idx_sel_c + IDX_W'(1);
        if (full_c && !pop_c) begin
          drop_c = 1'b1;
        end else begin
          push_c = 1'b1;
        end
      end
    end

    if (frame_done) begin
      state_nxt    = IDLE;
      word_idx_nxt = '0;
    end

    overflow_nxt = overflow | drop_c;

    // Drain counts only words already queued when the frame ended, including one pushed alongside.
    if (frame_done) begin
      if (drain_active) begin
        overflow_nxt = 1'b1;
      end
      drain_cnt_nxt    = fill_c;
      drain_active_nxt = (fill_c != '0);
      written_nxt      = (fill_c == '0);
    end else if (drain_active && pop_c) begin
      drain_cnt_nxt = drain_cnt - CNT_W'(1);
      if (drain_cnt == CNT_W'(1)) begin
        drain_active_nxt = 1'b0;
        written_nxt      = 1'b1;
      end
    end

    if (load_c) begin
      valid_nxt = (avail_c != '0);
      if (avail_c != '0) begin
        addr_nxt = mem[rd_ptr_c].addr;
        data_nxt = mem[rd_ptr_c].data;
      end
    end
  end

  always_ff @(posedge p_clk) begin
    if (push_c) begin
      mem[wptr] <= entry_c;
    end
  end

  always_ff @(posedge p_clk) begin
    if (flush_c) begin
      slot          <= '0;
      word_idx      <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      drain_cnt     <= '0;
      drain_active  <= 1'b0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_written <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      slot          <= slot_nxt;
      word_idx      <= word_idx_nxt;
      wptr          <= wptr + PTR_W'(push_c);
      rptr          <= rptr + PTR_W'(pop_c);
      count         <= fill_c;
      drain_cnt     <= drain_cnt_nxt;
      drain_active  <= drain_active_nxt;
      wr_valid      <= valid_nxt;
      wr_addr       <= addr_nxt;
      wr_data       <= data_nxt;
      frame_written <= written_nxt;
      overflow      <= overflow_nxt;
    end
  end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Sits directly downstream of the camera capture stage in the p_clk domain, between it and the DDR write port.
- Accepts 128-bit pixel words (8 RGB565 pixels) on a valid strobe and assigns each word a DDR word address inside one of six frame slots.
- Buffers words and addresses in a small FIFO and issues them to the memory write port with a valid/ready handshake.
- Reports per-frame completion once every word of a frame has been accepted downstream.

Parameters:
- FIFO_DEPTH, 16: FIFO entries; power of 2, at least 4.
- FRAME_WORDS, 38400: 128-bit words per frame (640x480x2 bytes / 16).
- ADDR_STEP, 4: address increment per word.
- FRAME_STRIDE, 25'h25800: address distance between slot bases (FRAME_WORDS*ADDR_STEP).
- NUM_SLOTS, 6: frame slots; the slot index comes from last_frame.

Ports:
- p_clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- take_pic, input, 1: synchronous flush; same effect as rst.
- p_data, input, 128: captured word.
- data_valid, input, 1: p_data valid this cycle; single-cycle strobe, no backpressure.
- frame_done, input, 1: one-cycle pulse after the last word of a frame.
- last_frame, input, 3: slot index 0..5 for the current frame.
- wr_valid, output, 1: write request valid.
- wr_ready, input, 1: memory accepts the request when wr_valid and wr_ready are both high.
- wr_addr, output, 25: word address of the request.
- wr_data, output, 128: data of the request.
- frame_written, output, 1: one-cycle pulse when the last word of a frame has been accepted.
- overflow, output, 1: sticky error flag.

Behaviour:
- Reset/flush (rst or take_pic): FIFO emptied, state IDLE, word_idx=0, slot=0, drain_cnt=0, drain_active=0. Outputs: wr_valid=0, wr_addr=0, wr_data=0, frame_written=0, overflow=0. take_pic takes effect even mid-handshake.
- States:
  - IDLE: waiting for the first word of a frame. On data_valid, latch slot=last_frame (values 5..7 clamp to 5), push the word with addr=slot*FRAME_STRIDE, set word_idx=1, go to FRAME.
  - FRAME: on each data_valid, push with addr = slot*FRAME_STRIDE + word_idx*ADDR_STEP, then word_idx+1. On frame_done, go to IDLE and start a drain.
- Drain:
  - Set drain_cnt = current FIFO occupancy, plus 1 if a word is pushed in the same cycle as frame_done (that word belongs to the ending frame).
  - Set drain_active=1.
  - Each handshake decrements drain_cnt.
  - When drain_cnt reaches 0 with drain_active set, pulse frame_written for one cycle on the next cycle and clear drain_active.
  - frame_done with an empty FIFO and no push: frame_written pulses exactly 1 cycle later.
  - A frame_done in IDLE (no words received) still produces a frame_written pulse.
- The next frame may begin while a drain is in progress. Its words queue behind the previous frame's words and do not count toward drain_cnt.
- A second frame_done while drain_active=1 sets overflow. drain_cnt then restarts from the current occupancy and one pulse is eventually produced.
- FIFO entries hold {addr,data}; addresses are fixed at push time, so slot changes never affect queued words.
- Push with FIFO full: word dropped, overflow set, word_idx still increments so later addresses stay pixel-aligned.
- word_idx >= FRAME_WORDS: word dropped, no push, overflow set. Addresses never leave the slot.
- Output stage:
  - wr_valid/wr_addr/wr_data are registered.
  - A word pushed into an empty FIFO at edge t drives wr_valid=1 after edge t+1 (1-cycle latency).
  - While wr_valid=1 and wr_ready=0, wr_addr and wr_data hold stable.
  - After a handshake, the next entry is presented in the following cycle with no bubble when the FIFO is non-empty: sustained 1 word/cycle.
- Simultaneous push and pop when full: the pop frees a slot for the push, so the word is not dropped.
- The block never applies backpressure upstream; overflow is the only loss indication and stays set until rst/take_pic.

Test Plan:
- Basic write, wr_ready=1: last_frame=2; 3 data_valid words D0..D2, then frame_done. Expect wr_addr 0x4B000, 0x4B004, 0x4B008 in order with matching data, and a single frame_written pulse 1 cycle after the D2 handshake; overflow=0.
- Backpressure: wr_ready=0 for 20 cycles while 5 words arrive. Expect wr_valid held with addr/data stable and no loss. Then wr_ready=1: 5 handshakes on consecutive cycles.
- Overflow: wr_ready=0; FIFO_DEPTH+2 words pushed. Expect overflow=1 and the 2 extra words dropped. After wr_ready=1, the 16 stored words drain with addresses idx 0..15. A subsequent word in the same frame gets idx 18 (address slot base+72).
- Frame boundary overlap: frame_done on the same cycle as the last push of frame A (slot 0); the first word of frame B (last_frame=1) arrives 2 cycles later while A is still draining. Expect frame_written after A's final word only, B's first address 0x25800, and no overflow.
- Flush: take_pic asserted with 6 words queued and wr_valid=1. Next cycle expect wr_valid=0, FIFO empty and no frame_written. A fresh frame with last_frame=5 starts at 0xBB800.
- Frame length limit: FRAME_WORDS+1 words with no stalls. Expect the last accepted address slot base+0x257FC, the extra word dropped and overflow=1.
